mini_cpu_pipe: RTL and testbench

//  Parametrised successor of the team's 4-stage mini CPU. 3-stage pipelined core (IF -> ID -> EX/WB).

---
 rtl/mini_cpu_pipe.sv | 180 ++++++++++++++++++
 tb/tb_mini_cpu_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_cpu_pipe.sv
// mini_cpu_pipe: 3-stage pipelined mini CPU (IF -> ID -> EX/WB).
// Has operand forwarding from EX into ID, a branch/jump flush, HALT, run/stall
// control and a combinational debug register read port.
// Optional feature: define MINI_CPU_MUL_EN to make op 9 a single-cycle MUL;
// without it op 9 is a NOP and no multiplier is built.
module mini_cpu_pipe #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    input  logic [3:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              flag_n,
    output logic              flag_z,
    output logic              retire,
    output logic              halted
);

    localparam logic [3:0] OP_LOADI = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_CMP   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_BZ    = 4'h7;
    localparam logic [3:0] OP_BN    = 4'h8;
`ifdef MINI_CPU_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'h9;
`endif
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Fetch / ID stage
    logic [PC_W-1:0]   r_pc;
    logic              r_id_valid;
    logic [15:0]       r_id_insn;
    // EX stage (operands already resolved in ID)
    logic              r_ex_valid;
    logic [3:0]        r_ex_op;
    logic [3:0]        r_ex_rd;
    logic [7:0]        r_ex_imm;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    // Architectural state
    logic              r_flag_n;
    logic              r_flag_z;
    logic              r_retire;
    logic              r_halted;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic [DATA_W-1:0] w_ex_res;
    logic              w_ex_wr;
    logic              w_ex_setf;
    logic              w_ex_jmp;
    logic              w_ex_halt;
    logic              w_we;
    logic [PC_W-1:0]   w_target;
    logic [3:0]        w_rs1;
    logic [3:0]        w_rs2;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    assign w_rs1    = r_id_insn[7:4];
    assign w_rs2    = r_id_insn[3:0];
    assign w_target = PC_W'(r_ex_imm);
    assign w_we     = w_ex_wr && (int'(r_ex_rd) < NREGS);

    // EX: compute result, write/flag enables and control-flow decision
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        w_ex_res  = '0;
        w_ex_wr   = 1'b0;
        w_ex_setf = 1'b0;
        w_ex_jmp  = 1'b0;
        w_ex_halt = 1'b0;
        if (r_ex_valid) begin
            case (r_ex_op)
                OP_LOADI: begin w_ex_res = DATA_W'($signed(r_ex_imm)); w_ex_wr = 1'b1; w_ex_setf = 1'b1; end
                OP_ADD:   begin w_ex_res = r_ex_a + r_ex_b; w_ex_wr = 1'b1; w_ex_setf = 1'b1; end
                OP_SUB:   begin w_ex_res = r_ex_a - r_ex_b; w_ex_wr = 1'b1; w_ex_setf = 1'b1; end
                OP_AND:   begin w_ex_res = r_ex_a & r_ex_b; w_ex_wr = 1'b1; w_ex_setf = 1'b1; end
                OP_OR:    begin w_ex_res = r_ex_a | r_ex_b; w_ex_wr = 1'b1; w_ex_setf = 1'b1; end
                OP_CMP:   begin w_ex_res = r_ex_a - r_ex_b; w_ex_setf = 1'b1; end
`ifdef MINI_CPU_MUL_EN
                OP_MUL:   begin w_ex_res = r_ex_a * r_ex_b; w_ex_wr = 1'b1; w_ex_setf = 1'b1; end
`endif
                OP_JMP:   w_ex_jmp = 1'b1;
                // Flags already hold the result of the preceding instruction
                OP_BZ:    w_ex_jmp = r_flag_z;
                OP_BN:    w_ex_jmp = r_flag_n;
                OP_HALT:  w_ex_halt = 1'b1;
                default:  ;
            endcase
        end
    end

    // ID: register read with bypass of the value EX writes this cycle
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (int'(w_rs1) < NREGS) begin
            w_rs1_val = (w_we && r_ex_rd == w_rs1) ? w_ex_res : r_regs[w_rs1];
        end
        if (int'(w_rs2) < NREGS) begin
            w_rs2_val = (w_we && r_ex_rd == w_rs2) ? w_ex_res : r_regs[w_rs2];
        end
    end

    // Pipeline control: fetch, stage advance, flush, halt and flags
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_pc       <= '0;
            r_id_valid <= 1'b0;
            r_id_insn  <= '0;
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_rd    <= '0;
            r_ex_imm   <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_flag_n   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_retire   <= 1'b0;
            r_halted   <= 1'b0;
        end else if (run) begin
            r_retire <= r_ex_valid;
            if (w_ex_setf) begin
                r_flag_n <= w_ex_res[DATA_W-1];
                r_flag_z <= (w_ex_res == '0);
            end
            if (w_ex_halt) begin
                // pc is deliberately left where it is from here on
                r_halted   <= 1'b1;
                r_id_valid <= 1'b0;
                r_ex_valid <= 1'b0;
            end else if (w_ex_jmp) begin
                r_pc       <= w_target;
                r_id_valid <= 1'b0;
                r_ex_valid <= 1'b0;
            end else if (!r_halted) begin
                r_pc       <= r_pc + PC_W'(1);
                r_id_valid <= 1'b1;
                r_id_insn  <= imem_data;
                r_ex_valid <= r_id_valid;
                r_ex_op    <= r_id_insn[15:12];
                r_ex_rd    <= r_id_insn[11:8];
                r_ex_imm   <= r_id_insn[7:0];
                r_ex_a     <= w_rs1_val;
                r_ex_b     <= w_rs2_val;
            end
        end
    end

    // Register file: written at the end of EX, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register file is built from flops, so clearing every
            // entry on reset is legal; a RAM-based file could not do this.
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (run && w_we) begin
            r_regs[r_ex_rd] <= w_ex_res;
        end
    end

    assign imem_addr = r_pc;
    assign dbg_rdata = (int'(dbg_raddr) < NREGS) ? r_regs[dbg_raddr] : '0;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;
    assign retire    = r_retire & run;
    assign halted    = r_halted;

endmodule

// File: tb/tb_mini_cpu_pipe.sv
// tb_mini_cpu_pipe: scoreboard bench for mini_cpu_pipe. An instruction-level
// reference model runs each program to HALT and queues one expected state per
// retired instruction; a monitor pops and compares on every retire pulse.
module tb_mini_cpu_pipe;
    localparam int DATA_W = 16;
    localparam int NREGS  = 16;
    localparam int PC_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic [3:0]        dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              flag_n;
    logic              flag_z;
    logic              retire;
    logic              halted;

    logic [15:0] rom [256];

    typedef struct {
        logic [3:0] sel;
        int         val;
        bit         fn;
        bit         fz;
    } exp_t;

    exp_t exp_q[$];
    int   ret_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   m_count  = 0;
    int   rel_cyc  = 0;

    mini_cpu_pipe #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .retire    (retire),
        .halted    (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign imem_data = rom[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction-set model: sequential execution from pc 0 until HALT.
    task automatic model_run();
        int regs [16];
        int pc, a, b, res, imm, op, rd;
        bit fn, fz, wr, setf, hlt;
        logic [15:0] ins;
        exp_t e;
        pc = 0; fn = 0; fz = 0;
        for (int i = 0; i < 16; i++) regs[i] = 0;
        m_count = 0;
        for (int step = 0; step < 1000; step++) begin
            ins = rom[8'(pc)];
            op  = int'(ins[15:12]);
            rd  = int'(ins[11:8]);
            a   = regs[ins[7:4]];
            b   = regs[ins[3:0]];
            imm = int'(ins[7:0]);
            wr = 0; setf = 0; hlt = 0; res = 0;
            pc = (pc + 1) % 256;
            case (op)
                0: begin res = (imm >= 128) ? imm + 65280 : imm; wr = 1; setf = 1; end
                1: begin res = (a + b) % 65536;         wr = 1; setf = 1; end
                2: begin res = (a - b + 65536) % 65536; wr = 1; setf = 1; end
                3: begin res = a & b;                   wr = 1; setf = 1; end
                4: begin res = a | b;                   wr = 1; setf = 1; end
                5: begin res = (a - b + 65536) % 65536; setf = 1; end
`ifdef MINI_CPU_MUL_EN
                9: begin res = int'((longint'(a) * longint'(b)) % 65536); wr = 1; setf = 1; end
`endif
                6: pc = imm % 256;
                7: if (fz) pc = imm % 256;
                8: if (fn) pc = imm % 256;
                15: hlt = 1;
                default: ;
            endcase
            if (wr && rd < NREGS) regs[rd] = res;
            if (setf) begin
                fn = (res >= 32768);
                fz = (res == 0);
            end
            e = '{sel: 4'(rd), val: regs[rd], fn: fn, fz: fz};
            exp_q.push_back(e);
            m_count++;
            if (hlt) break;
        end
    endtask

    // Reset the core, load a program, check reset state, queue expectations.
    task automatic start_prog(input logic [15:0] p[$]);
        reset = 1'b1;
        run   = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        foreach (p[i]) rom[i] = p[i];
        ret_log.delete();
        tick();
        tick();
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_retire",    32'(retire),    0);
        check("rst_halted",    32'(halted),    0);
        check("rst_flag_n",    32'(flag_n),    0);
        check("rst_flag_z",    32'(flag_z),    0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 0);
        model_run();
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    // Run to HALT (optionally toggling run), then check the halted state.
    task automatic finish_prog(input bit rand_run);
        int n = 0;
        logic [PC_W-1:0] pc_hold;
        while (!halted && n < 3000) begin
            tick();
            if (rand_run) run = ($urandom_range(0, 3) != 0);
            n++;
        end
        run = 1'b1;
        check("halt_reached", 32'(halted), 1);
        pc_hold = imem_addr;
        repeat (6) tick();
        check("pc_frozen_after_halt", 32'(imem_addr), 32'(pc_hold));
        check("halted_sticky", 32'(halted), 1);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        check("retire_count", 32'(ret_log.size()), 32'(m_count));
    endtask

    task automatic gen_rand(input int len, output logic [15:0] p[$]);
        p.delete();
        for (int i = 0; i < len - 1; i++) begin
            logic [15:0] w;
            logic [3:0]  op;
            w  = 16'($urandom);
            op = 4'($urandom_range(0, 14));
            w[15:12] = op;
            w[11]    = 1'b0;
            if (op inside {4'd6, 4'd7, 4'd8}) begin
                w[7:0] = 8'($urandom_range(i + 1, len - 1));
            end else if (op != 4'd0) begin
                w[7] = 1'b0;
                w[3] = 1'b0;
            end
            p.push_back(w);
        end
        p.push_back(16'hF000);
    endtask

    // Monitor: on each retire pulse compare the architectural state.
    initial begin
        exp_t e;
        dbg_raddr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
            end else if (retire) begin
                ret_log.push_back(cyc);
                check("retire_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    dbg_raddr = e.sel;
                    #1;
                    check($sformatf("reg_r%0d", e.sel), 32'(dbg_rdata), 32'(e.val));
                    check("flag_n", 32'(flag_n), 32'(e.fn));
                    check("flag_z", 32'(flag_z), 32'(e.fz));
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [15:0] p[$];
        logic [PC_W-1:0] pc_hold;

        // Back-to-back dependents, SUB negative, CMP equal
        p = '{16'h0105, 16'h0203, 16'h1312, 16'h2421, 16'h5011, 16'hF000};
        start_prog(p);
        finish_prog(1'b0);
        check("first_retire_latency", 32'(ret_log[0] - rel_cyc), 3);
        check("retire_consec_1", 32'(ret_log[1] - ret_log[0]), 1);
        check("retire_consec_2", 32'(ret_log[2] - ret_log[1]), 1);
        check("cmp_flag_z", 32'(flag_z), 1);
        check("cmp_flag_n", 32'(flag_n), 0);

        // Same program with a 5-cycle stall while ADD is in EX
        start_prog(p);
        repeat (4) tick();
        pc_hold = imem_addr;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc_hold", 32'(imem_addr), 32'(pc_hold));
            check("stall_retire_low", 32'(retire), 0);
        end
        run = 1'b1;
        finish_prog(1'b0);

        // JMP 0x10 at pc 2; pc 3,4 must never execute
        p = '{16'h0101, 16'h0202, 16'h6410, 16'h0307, 16'h0407};
        repeat (11) p.push_back(16'hF000);
        p.push_back(16'h0509);
        p.push_back(16'h3444);
        p.push_back(16'hF300);
        start_prog(p);
        finish_prog(1'b0);
        check("jmp_target_delay", 32'(ret_log[3] - ret_log[2]), 3);

        // BZ not taken (no bubble), BN taken (2 bubbles)
        p = '{16'h0101, 16'h7008, 16'h02FF, 16'h800A, 16'h0305, 16'h0306,
              16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'h0404, 16'hF300};
        start_prog(p);
        finish_prog(1'b0);
        check("bz_fallthrough_delay", 32'(ret_log[2] - ret_log[1]), 1);
        check("bn_taken_delay", 32'(ret_log[4] - ret_log[3]), 3);

        // MUL 0x0102 * 0x0003 (NOP when the multiplier is not built)
        p = '{16'h017F, 16'h1111, 16'h0204, 16'h1112, 16'h0203, 16'h9512, 16'hF000};
        start_prog(p);
        finish_prog(1'b0);

        // Random program interrupted by reset mid-flight
        gen_rand(40, p);
        start_prog(p);
        repeat (15) tick();

        // Random programs with random run/stall
        for (int k = 0; k < 6; k++) begin
            gen_rand(40, p);
            start_prog(p);
            finish_prog(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
